uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Host-side UART transmit path: buffers parallel bytes written by the host in a
//  FIFO and serialises them onto tx as asynchronous frames. It is the sending
//  end for the UART receive/loopback block: its tx line drives that block's rx.
//  Contains its own per-bit clock divider, so it needs only the system clock.
// PARAMETERS
//  CLKS_PER_BIT  434  system clocks per serial bit (50 MHz / 115200); must be >= 2
//  DEPTH         16   FIFO entries; power of two; ADDR_W = log2(DEPTH)
//  PARITY_EN     0    1 = insert parity bit after D7
//  PARITY_ODD    0    0 = even parity, 1 = odd parity (used only if PARITY_EN=1)
//  STOP_BITS     1    number of stop bits, 1 or 2
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  reset     in   1  asynchronous, active-low reset
//  wr        in   1  write strobe; byte taken on a clk edge with wr=1 and full=0
//  data_in   in   8  byte to send, D0 transmitted first
//  full      out  1  FIFO holds DEPTH bytes; writes ignored
//  empty     out  1  FIFO holds no bytes
//  overflow  out  1  one-cycle pulse: wr=1 while full=1 (byte dropped)
//  tx        out  1  serial line, idle high
//  busy      out  1  high from start bit through last stop-bit cycle
//  txDone    out  1  one-cycle pulse in final clock of the last stop bit
// BEHAVIOUR
//  Reset (reset=0, any time, incl. mid-frame): FIFO pointers/count cleared,
//   FSM -> IDLE, bit counter 0, tx=1, busy=0, txDone=0, overflow=0, empty=1,
//   full=0. In-flight frame and buffered bytes discarded; line returns high.
//  FIFO: count 0..DEPTH, pointers wrap modulo DEPTH; full/empty registered from
//   count. Write accepted iff full=0 at the edge (same-edge pop does not free a
//   slot for a write). Pop happens only on the IDLE->START transition.
//   Simultaneous accepted write and pop: count unchanged, both pointers advance.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE:  tx=1. If empty=0: load shift reg from FIFO head, pop, clear baud
//          counter, -> START (tx=0 from the next cycle). Else stay.
//   START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit index 0.
//   DATA:  tx=shift[0] for CLKS_PER_BIT cycles each, shift right; after bit 7
//          -> PARITY if PARITY_EN else STOP.
//   PARITY: tx = ^byte ^ PARITY_ODD for CLKS_PER_BIT cycles -> STOP.
//   STOP:  tx=1 for STOP_BITS*CLKS_PER_BIT cycles; txDone=1 in last cycle;
//          then IDLE.
//  Baud counter: counts 0..CLKS_PER_BIT-1 in every non-IDLE state, restarts
//   at 0 on each bit boundary; width $clog2(CLKS_PER_BIT).
//  Frame length = (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles.
//  Latency: wr into empty FIFO at edge k -> empty=0 after k -> pop at k+1 ->
//   tx low from k+1 to k+1+CLKS_PER_BIT.
//  Back-to-back: IDLE lasts exactly one cycle between frames when FIFO
//   non-empty (1 extra idle-high clock, within receiver stop tolerance).
//  busy=1 in START..STOP inclusive; busy=0 in IDLE.
//  tx is driven from a register (glitch-free).
// TESTING (CLKS_PER_BIT=4, DEPTH=4 unless noted)
//  1 Reset -> tx=1, empty=1, full=0, busy=0; hold 20 clks, tx stays 1.
//  2 Write 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1 each 4 clks; txDone once; 40 clk.
//  3 Write 5 bytes in 5 cycles while idle -> 5th accepted (one popped), 6th
//    write in next cycle sets overflow; all accepted bytes sent in order.
//  4 PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2, byte 0x03 -> parity bit 1,
//    two stop bits, frame 48 clks.
//  5 reset=0 during DATA bit 3 -> tx=1 immediately (async), FIFO empty, no txDone.
//  6 Loop tx into the UART receive block rx; send 0x00,0xFF,0x55 -> received
//    bytes match, no framing errors.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a host-side byte FIFO and built-in baud divider.
// Frames are start, D0..D7, optional parity, then 1 or 2 stop bits; tx idles high.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DEPTH        = 16,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic [7:0] data_in,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       tx,
    output logic       busy,
    output logic       txDone
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, empty_q, ovf_q;
    logic              push, pop;

    state_t            state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic              stop_q;
    logic [7:0]        shift_q;
    logic              par_q;
    logic              tx_q, busy_q, done_q;
    logic              baud_last, last_stop;

    // A pop is only ever the IDLE->START hand-off; full blocks a write even if that pop frees a slot.
    always_comb begin
        push    = wr && !full_q;
        pop     = (state_q == IDLE) && !empty_q;
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
        baud_last = (baud_q == BAUD_LAST);
        last_stop = (STOP_BITS == 1) || stop_q;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
            empty_q <= (count_d == '0);
            ovf_q   <= wr && full_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (!empty_q) begin
                        shift_q <= mem[rd_ptr_q];
                        par_q   <= (^mem[rd_ptr_q]) ^ PARITY_ODD;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            if (PARITY_EN) begin
                                tx_q    <= par_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                stop_q  <= 1'b0;
                                state_q <= STOP;
                            end
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        stop_q  <= 1'b0;
                        state_q <= STOP;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    // Raised one edge early so the registered pulse lands in the final stop cycle.
                    if (last_stop && baud_q == BAUD_PRE)
                        done_q <= 1'b1;
                    if (baud_last) begin
                        baud_q <= '0;
                        if (last_stop) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = ovf_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign txDone   = done_q;

endmodule
